kernel_ram_arbiter: RTL and testbench

Shares the single read port and single write port of the RAM between two start/ready/done accelerator kernels (kernel 0, kernel 1).
- Accepts run requests from the host and grants whole-kernel RAM ownership round-robin.
- Issues each kernel's start pulse and routes the RAM ports to the owner until it reports done.
- Pulses a per-client acknowledge on completion.
- Sits between the kernels and the RAM instance, replacing the direct kernel-to-RAM hookup.

---
 rtl/kernel_ram_arbiter_if.sv | 37 +++
 rtl/kernel_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_kernel_ram_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_ram_arbiter_if.sv
// Kernel-side RAM and start/ready/done bundle for kernel_ram_arbiter.
// The master modport is the arbiter; the slave modport is the kernel.
interface kernel_ram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic                  ready;
    logic                  done;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        output start,
        output rdata,
        input  ready,
        input  done,
        input  raddr,
        input  waddr,
        input  wen,
        input  wdata
    );

    modport slave (
        input  start,
        input  rdata,
        output ready,
        output done,
        output raddr,
        output waddr,
        output wen,
        output wdata
    );
endinterface

// File: rtl/kernel_ram_arbiter.sv
// Round-robin whole-run arbiter sharing one RAM read port and one write port between two kernels.
// Optional watchdog abort is enabled by defining ARB_TIMEOUT_EN.
module kernel_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_0,
    input  logic                  req_1,
    output logic                  ack_0,
    output logic                  ack_1,
    output logic                  busy,
    output logic                  owner,
    output logic                  err,
    kernel_ram_arbiter_if.master  k0,
    kernel_ram_arbiter_if.master  k1,
    output logic [ADDR_WIDTH-1:0] ram_raddr_0,
    input  logic [DATA_WIDTH-1:0] ram_rdata_0,
    output logic [ADDR_WIDTH-1:0] ram_waddr_0,
    output logic                  ram_wen_0,
    output logic [DATA_WIDTH-1:0] ram_wdata_0
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAccept,
        StRun,
        StFin
    } state_e;

    state_e state;
    logic   pending_0;
    logic   pending_1;
    logic   last;
    logic   grant_0;
    logic   grant_1;
    logic   cur_ready;
    logic   cur_done;
    logic   active;
    logic   timeout;

    assign cur_ready = owner ? k1.ready : k0.ready;
    assign cur_done  = owner ? k1.done  : k0.done;
    assign active    = (state == StStart) || (state == StAccept) || (state == StRun);

    // Tie goes to the kernel that did not finish last.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (state == StIdle) begin
            if (pending_0 && pending_1) begin
                grant_0 = last;
                grant_1 = ~last;
            end else begin
                grant_0 = pending_0;
                grant_1 = pending_1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntWidth-1:0] tmo_cnt;

    assign timeout = active && (tmo_cnt == CntWidth'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (grant_0 || grant_1) begin
            tmo_cnt <= '0;
        end else if (active) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cycles;

    assign timeout               = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            pending_0 <= 1'b0;
            pending_1 <= 1'b0;
            last      <= 1'b1;
            owner     <= 1'b0;
            ack_0     <= 1'b0;
            ack_1     <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack_0     <= 1'b0;
            ack_1     <= 1'b0;
            err       <= 1'b0;
            // A request during the owner's own run re-arms its pending bit.
            pending_0 <= (pending_0 & ~grant_0) | req_0;
            pending_1 <= (pending_1 & ~grant_1) | req_1;
            if (timeout) begin
                err   <= 1'b1;
                last  <= owner;
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (grant_0 || grant_1) begin
                            owner <= grant_1;
                            state <= StStart;
                        end
                    end
                    StStart: begin
                        if (cur_ready) begin
                            state <= StAccept;
                        end
                    end
                    // A stale done from the previous run is ignored until ready drops.
                    StAccept: begin
                        if (!cur_ready) begin
                            state <= StRun;
                        end
                    end
                    StRun: begin
                        if (cur_done && cur_ready) begin
                            ack_0 <= ~owner;
                            ack_1 <= owner;
                            state <= StFin;
                        end
                    end
                    StFin: begin
                        last  <= owner;
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign busy     = (state != StIdle);
    assign k0.start = (state == StStart) && !owner && k0.ready;
    assign k1.start = (state == StStart) && owner && k1.ready;
    assign k0.rdata = ram_rdata_0;
    assign k1.rdata = ram_rdata_0;

    always_comb begin
        ram_raddr_0 = '0;
        ram_waddr_0 = '0;
        ram_wdata_0 = '0;
        ram_wen_0   = 1'b0;
        if (state != StIdle) begin
            if (owner) begin
                ram_raddr_0 = k1.raddr;
                ram_waddr_0 = k1.waddr;
                ram_wdata_0 = k1.wdata;
                ram_wen_0   = k1.wen && !timeout;
            end else begin
                ram_raddr_0 = k0.raddr;
                ram_waddr_0 = k0.waddr;
                ram_wdata_0 = k0.wdata;
                ram_wen_0   = k0.wen && !timeout;
            end
        end
    end

endmodule

// File: tb/tb_kernel_ram_arbiter.sv
// Directed self-checking bench for kernel_ram_arbiter with two behavioural kernels and a RAM model.
// Define ARB_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_kernel_ram_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_0;
    logic          req_1;
    logic          ack_0;
    logic          ack_1;
    logic          busy;
    logic          owner;
    logic          err;
    logic [AW-1:0] ram_raddr_0;
    logic [DW-1:0] ram_rdata_0;
    logic [AW-1:0] ram_waddr_0;
    logic          ram_wen_0;
    logic [DW-1:0] ram_wdata_0;

    kernel_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) k0_if ();
    kernel_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) k1_if ();

    kernel_ram_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_0      (req_0),
        .req_1      (req_1),
        .ack_0      (ack_0),
        .ack_1      (ack_1),
        .busy       (busy),
        .owner      (owner),
        .err        (err),
        .k0         (k0_if),
        .k1         (k1_if),
        .ram_raddr_0(ram_raddr_0),
        .ram_rdata_0(ram_rdata_0),
        .ram_waddr_0(ram_waddr_0),
        .ram_wen_0  (ram_wen_0),
        .ram_wdata_0(ram_wdata_0)
    );

    // Kernel-side drive variables
    logic          k0_ready, k0_done, k0_wen;
    logic [AW-1:0] k0_raddr, k0_waddr;
    logic [DW-1:0] k0_wdata;
    logic          k1_ready, k1_done, k1_wen;
    logic [AW-1:0] k1_raddr, k1_waddr;
    logic [DW-1:0] k1_wdata;
    logic          k1_hog;
    logic          k0_hang;
    int            k0_lag;
    int            k0_runs;

    assign k0_if.ready = k0_ready;
    assign k0_if.done  = k0_done;
    assign k0_if.raddr = k0_raddr;
    assign k0_if.waddr = k0_waddr;
    assign k0_if.wen   = k0_wen;
    assign k0_if.wdata = k0_wdata;
    assign k1_if.ready = k1_ready;
    assign k1_if.done  = k1_done;
    assign k1_if.raddr = k1_raddr;
    // Kernel 1 can be forced to hammer the write port while it does not own the RAM.
    assign k1_if.waddr = k1_hog ? 32'd12 : k1_waddr;
    assign k1_if.wen   = k1_hog ? 1'b1 : k1_wen;
    assign k1_if.wdata = k1_hog ? 32'd99 : k1_wdata;

    // RAM model: one synchronous read port, one write port, plus a host preload port.
    logic [DW-1:0] mem [0:63];
    logic          host_we;
    logic [5:0]    host_addr;
    logic [DW-1:0] host_data;

    always @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_data;
        else if (ram_wen_0) mem[ram_waddr_0[5:0]] <= ram_wdata_0;
        ram_rdata_0 <= mem[ram_raddr_0[5:0]];
    end

    // Kernel 0: RAM[12] = RAM[10] + 2
    initial begin
        k0_ready = 1'b1; k0_done = 1'b0; k0_wen = 1'b0;
        k0_raddr = '0; k0_waddr = '0; k0_wdata = '0; k0_runs = 0;
        forever begin
            @(negedge clk);
            if (k0_if.start) begin
                repeat (k0_lag) @(negedge clk);
                k0_ready = 1'b0; k0_done = 1'b0; k0_raddr = 32'd10;
                @(negedge clk);
                k0_waddr = 32'd12; k0_wdata = k0_if.rdata + 32'd2; k0_wen = 1'b1;
                @(negedge clk);
                k0_wen = 1'b0;
                while (k0_hang) @(negedge clk);
                k0_runs = k0_runs + 1;
                k0_done = 1'b1; k0_ready = 1'b1;
            end
        end
    end

    // Kernel 1: RAM[22] = RAM[20] + 5
    initial begin
        k1_ready = 1'b1; k1_done = 1'b0; k1_wen = 1'b0;
        k1_raddr = '0; k1_waddr = '0; k1_wdata = '0;
        forever begin
            @(negedge clk);
            if (k1_if.start) begin
                @(negedge clk);
                k1_ready = 1'b0; k1_done = 1'b0; k1_raddr = 32'd20;
                @(negedge clk);
                k1_waddr = 32'd22; k1_wdata = k1_if.rdata + 32'd5; k1_wen = 1'b1;
                @(negedge clk);
                k1_wen = 1'b0;
                k1_done = 1'b1; k1_ready = 1'b1;
            end
        end
    end

    // Event counters
    int ack0_cnt = 0, ack1_cnt = 0, k0_starts = 0, k1_starts = 0;
    int clash = 0, bad_start = 0, leak = 0, err_cnt = 0;

    always @(negedge clk) begin
        if (ack_0) ack0_cnt <= ack0_cnt + 1;
        if (ack_1) ack1_cnt <= ack1_cnt + 1;
        if (k0_if.start) k0_starts <= k0_starts + 1;
        if (k1_if.start) k1_starts <= k1_starts + 1;
        if (k0_if.start && k1_if.start) clash <= clash + 1;
        if ((k0_if.start && owner) || (k1_if.start && !owner)) bad_start <= bad_start + 1;
        if (ram_wen_0 && (!busy || (!owner && !k0_if.wen) || (owner && !k1_if.wen)))
            leak <= leak + 1;
        if (err) err_cnt <= err_cnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_req(input logic r0, input logic r1);
        @(negedge clk);
        req_0 = r0; req_1 = r1;
        @(negedge clk);
        req_0 = 1'b0; req_1 = 1'b0;
    endtask

    task automatic ram_put(input logic [5:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_data = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic wait_ack(input int which, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((which == 0) ? ack_0 : ack_1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_any_ack(input int budget, output int who);
        who = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (ack_0) begin who = 0; break; end
            if (ack_1) begin who = 1; break; end
        end
    endtask

    task automatic wait_start0(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (k0_if.start) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench hung");
    end

    int cyc, who, base0, base_runs;

    initial begin
        rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
        host_we = 1'b0; host_addr = '0; host_data = '0;
        k1_hog = 1'b0; k0_hang = 1'b0; k0_lag = 1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ack0", ack_0, 0);
        check("rst_ack1", ack_1, 0);
        check("rst_err", err, 0);
        check("rst_owner", owner, 0);
        check("rst_start0", k0_if.start, 0);
        check("rst_start1", k1_if.start, 0);
        check("rst_wen", ram_wen_0, 0);
        check("rst_raddr", ram_raddr_0, 0);
        check("rst_waddr", ram_waddr_0, 0);
        check("rst_wdata", ram_wdata_0, 0);
        ram_put(6'd10, 32'd15);
        ram_put(6'd20, 32'd40);
        @(negedge clk);
        rst = 1'b0;

        // Single run of kernel 0
        pulse_req(1'b1, 1'b0);
        check("single_start_early", k0_if.start, 0);
        wait_start0(10, cyc);
        check("single_start_lat", cyc, 1);
        check("single_busy", busy, 1);
        check("single_owner", owner, 0);
        wait_ack(0, 30, cyc);
        check("single_ack_lat", cyc, 4);
        check("single_busy_fin", busy, 1);
        @(negedge clk);
        check("single_ack_pulse", ack_0, 0);
        check("single_busy_done", busy, 0);
        check("single_ram12", mem[12], 17);
        check("single_ack0_cnt", ack0_cnt, 1);
        check("single_no_k1", k1_starts, 0);

        // Simultaneous pair after reset: kernel 0 first
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        pulse_req(1'b1, 1'b1);
        wait_any_ack(60, who);
        check("pairA_first", who, 0);
        wait_any_ack(60, who);
        check("pairA_second", who, 1);
        check("pairA_ram22", mem[22], 45);

        // Write isolation: kernel 1 drives wen during kernel 0's run
        ram_put(6'd12, 32'd0);
        k1_hog = 1'b1;
        pulse_req(1'b1, 1'b0);
        wait_ack(0, 40, cyc);
        check("iso_ack_seen", (cyc > 0), 1);
        @(negedge clk);
        k1_hog = 1'b0;
        check("iso_ram12", mem[12], 17);
        check("iso_leak", leak, 0);

        // Kernel 0 finished last, so kernel 1 wins this tie
        pulse_req(1'b1, 1'b1);
        wait_any_ack(60, who);
        check("pairB_first", who, 1);
        wait_any_ack(60, who);
        check("pairB_second", who, 0);

        // Stale done: ack only after the new run completes
        k0_lag = 4;
        @(negedge clk);
        base0 = ack0_cnt;
        base_runs = k0_runs;
        check("stale_done_high", k0_done, 1);
        pulse_req(1'b1, 1'b0);
        wait_ack(0, 60, cyc);
        check("stale_ack_seen", (cyc > 0), 1);
        check("stale_run_done", k0_runs, base_runs + 1);
        repeat (10) @(negedge clk);
        check("stale_one_ack", ack0_cnt, base0 + 1);
        k0_lag = 1;

        // Re-arm during own run gives one further run
        base0 = ack0_cnt;
        pulse_req(1'b1, 1'b0);
        wait_start0(10, cyc);
        check("rearm_start", (cyc > 0), 1);
        repeat (2) @(negedge clk);
        req_0 = 1'b1;
        @(negedge clk);
        req_0 = 1'b0;
        wait_ack(0, 40, cyc);
        check("rearm_ack1", (cyc > 0), 1);
        wait_ack(0, 40, cyc);
        check("rearm_ack2", (cyc > 0), 1);
        repeat (8) @(negedge clk);
        check("rearm_cnt", ack0_cnt, base0 + 2);
        check("rearm_idle", busy, 0);

        // Reset mid-run with kernel 1 pending
        k0_hang = 1'b1;
        base0 = ack0_cnt;
        pulse_req(1'b1, 1'b0);
        wait_start0(10, cyc);
        repeat (3) @(negedge clk);
        req_1 = 1'b1;
        @(negedge clk);
        req_1 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_wen", ram_wen_0, 0);
        check("midrst_ack0", ack_0, 0);
        check("midrst_owner", owner, 0);
        k0_hang = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_pend_clr", busy, 0);
        check("midrst_no_ack", ack0_cnt, base0);
        pulse_req(1'b0, 1'b1);
        wait_ack(1, 40, cyc);
        check("midrst_k1_ack", (cyc > 0), 1);

`ifdef ARB_TIMEOUT_EN
        // Hung kernel 0: watchdog aborts, pending kernel 1 then runs
        k0_hang = 1'b1;
        repeat (4) @(negedge clk);
        base0 = ack0_cnt;
        pulse_req(1'b1, 1'b0);
        wait_start0(10, cyc);
        req_1 = 1'b1;
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            req_1 = 1'b0;
            if (err) begin
                cyc = i;
                break;
            end
        end
        check("tmo_err_lat", cyc, 16);
        check("tmo_busy", busy, 0);
        @(negedge clk);
        check("tmo_err_pulse", err, 0);
        k0_hang = 1'b0;
        wait_ack(1, 60, cyc);
        check("tmo_k1_ack", (cyc > 0), 1);
        repeat (4) @(negedge clk);
        check("tmo_no_ack0", ack0_cnt, base0);
        check("tmo_err_cnt", err_cnt, 1);
        check("tot_k0_starts", k0_starts, 9);
        check("tot_k1_starts", k1_starts, 4);
        check("tot_ack1", ack1_cnt, 4);
`else
        repeat (4) @(negedge clk);
        check("no_err", err_cnt, 0);
        check("tot_k0_starts", k0_starts, 8);
        check("tot_k1_starts", k1_starts, 3);
        check("tot_ack1", ack1_cnt, 3);
`endif
        check("tot_ack0", ack0_cnt, 7);
        check("start_clash", clash, 0);
        check("start_non_owner", bad_start, 0);
        check("wen_leak", leak, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
